// File: rtl/cic_pkg.sv
// cic_pkg: shared width helpers and FSM state type for the cic_decim_mc decimator.
package cic_pkg;
    typedef enum logic [1:0] {IDLE, COMB, OUT} cic_state_t;

    function automatic int cic_width(input int n, input int r, input int m);
        return n * $clog2(r * m) + 2;
    endfunction

    function automatic int cic_chan_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction
endpackage

// File: rtl/cic_integrator_bank.sv
// cic_integrator_bank: per-channel N-stage integrator chains plus the decimation event counter.
module cic_integrator_bank
    import cic_pkg::*;
#(
    parameter int N  = 4,
    parameter int R  = 64,
    parameter int CH = 2,
    parameter int B  = 26
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic [CH-1:0]   i_x,
    output logic [CH*B-1:0] o_last,
    output logic            o_event
);
    localparam int RW = (R > 1) ? $clog2(R) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(R - 1);

    logic [B-1:0]  r_int [CH][N];
    logic [B-1:0]  w_nxt [CH][N];
    logic [B-1:0]  w_acc;
    logic [RW-1:0] r_cnt;
    logic          r_evt;

    // Each stage adds the freshly updated value of the stage before it.
    always_comb begin
        w_acc = '0;
        for (int c = 0; c < CH; c++) begin
            w_acc = r_int[c][0] + (i_x[c] ? B'(1) : {B{1'b1}});
            w_nxt[c][0] = w_acc;
            for (int k = 1; k < N; k++) begin
                w_acc = r_int[c][k] + w_acc;
                w_nxt[c][k] = w_acc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_evt <= 1'b0;
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < N; k++)
                    r_int[c][k] <= '0;
        end else begin
            r_evt <= i_valid && (r_cnt == R_LAST);
            if (i_valid) begin
                r_cnt <= r_cnt + 1'b1;
                for (int c = 0; c < CH; c++)
                    for (int k = 0; k < N; k++)
                        r_int[c][k] <= w_nxt[c][k];
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_last
        assign o_last[g*B +: B] = r_int[g][N-1];
    end

    assign o_event = r_evt;
endmodule

// File: rtl/cic_decim_mc.sv
// cic_decim_mc: multi-channel PDM CIC decimator with one time-shared comb engine.
// Define CIC_ROUND_EN for round-half-up with positive saturation (one extra cycle per channel).
module cic_decim_mc
    import cic_pkg::*;
#(
    parameter int N  = 4,
    parameter int R  = 64,
    parameter int M  = 1,
    parameter int CH = 2,
    parameter int OW = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     x_valid,
    input  logic [CH-1:0]            x_in,
    output logic [OW-1:0]            y_data,
    output logic [cic_chan_w(CH)-1:0] y_chan,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic                     overrun,
    input  logic                     overrun_clr
);
    localparam int B   = cic_width(N, R, M);
    localparam int CW  = cic_chan_w(CH);
    localparam int SIW = (N > 1) ? $clog2(N) : 1;
`ifdef CIC_ROUND_EN
    localparam int NS  = N + 1;
`else
    localparam int NS  = N;
`endif
    localparam int SW  = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(NS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CH - 1);

    cic_state_t      r_state, w_next;
    logic [CW-1:0]   r_c;
    logic [SW-1:0]   r_s;
    logic [B-1:0]    r_v;
    logic [B-1:0]    r_snap [CH];
    logic [B-1:0]    r_dly [CH][N][M];
    logic [OW-1:0]   r_y;
    logic            r_ovr;
    logic [CH*B-1:0] w_last;
    logic            w_evt;
    logic [SIW-1:0]  w_sidx;
    logic [B-1:0]    w_vin, w_vout;
    logic [OW-1:0]   w_y;
    logic            w_hs, w_accept, w_s_last, w_c_last, w_step, w_load;

    cic_integrator_bank #(.N(N), .R(R), .CH(CH), .B(B)) u_integ (
        .clk     (clk),
        .rst     (rst),
        .i_valid (x_valid),
        .i_x     (x_in),
        .o_last  (w_last),
        .o_event (w_evt)
    );

    assign w_sidx   = r_s[SIW-1:0];
    assign w_vin    = (r_s == '0) ? r_snap[r_c] : r_v;
    assign w_vout   = w_vin - r_dly[r_c][w_sidx][M-1];
    assign w_s_last = r_s == S_LAST;
    assign w_c_last = r_c == C_LAST;
    assign w_hs     = (r_state == OUT) && y_ready;
    assign w_accept = (r_state == IDLE) && w_evt;
    assign w_load   = (r_state == COMB) && w_s_last;

`ifdef CIC_ROUND_EN
    localparam int KS = (B > OW) ? B - OW - 1 : 0;
    localparam logic [B-1:0] K = (B > OW) ? (B'(1) << KS) : '0;
    logic [B-1:0] w_sum;
    // Last step of a channel is the rounding pass over the finished comb value.
    assign w_sum  = r_v + K;
    assign w_y    = (!r_v[B-1] && w_sum[B-1]) ? {1'b0, {(OW-1){1'b1}}} : w_sum[B-1 -: OW];
    assign w_step = (r_state == COMB) && !w_s_last;
`else
    assign w_y    = w_vout[B-1 -: OW];
    assign w_step = r_state == COMB;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_evt ? COMB : IDLE;
            COMB:    w_next = w_s_last ? OUT : COMB;
            OUT:     w_next = y_ready ? (w_c_last ? IDLE : COMB) : OUT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c   <= '0;
            r_s   <= '0;
            r_v   <= '0;
            r_y   <= '0;
            r_ovr <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                r_snap[c] <= '0;
                for (int k = 0; k < N; k++)
                    for (int m = 0; m < M; m++)
                        r_dly[c][k][m] <= '0;
            end
        end else begin
            // An event arriving mid-frame is dropped entirely; set beats clear.
            r_ovr <= (w_evt && (r_state != IDLE)) || (r_ovr && !overrun_clr);
            if (w_accept) begin
                for (int c = 0; c < CH; c++)
                    r_snap[c] <= w_last[c*B +: B];
                r_c <= '0;
                r_s <= '0;
            end
            if (r_state == COMB)
                r_s <= r_s + 1'b1;
            if (w_step) begin
                r_v <= w_vout;
                r_dly[r_c][w_sidx][0] <= w_vin;
                for (int m = 1; m < M; m++)
                    r_dly[r_c][w_sidx][m] <= r_dly[r_c][w_sidx][m-1];
            end
            if (w_load)
                r_y <= w_y;
            if (w_hs && !w_c_last) begin
                r_c <= r_c + 1'b1;
                r_s <= '0;
            end
        end
    end

    assign y_data  = r_y;
    assign y_chan  = r_c;
    assign y_valid = r_state == OUT;
    assign overrun = r_ovr;
endmodule

// File: tb/tb_cic_decim_mc.sv
// tb_cic_decim_mc: directed and random checks of cic_decim_mc against a binomial-comb reference model.
module tb_cic_decim_mc;
    localparam int N  = 4;
    localparam int R  = 64;
    localparam int M  = 1;
    localparam int CH = 2;
    localparam int OW = 16;
    localparam int B  = N * $clog2(R * M) + 2;
    localparam longint MASK = (longint'(1) << B) - 1;
`ifdef CIC_ROUND_EN
    localparam int RND_EXP = 1;
`else
    localparam int RND_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst, x_valid, y_valid, y_ready, overrun, overrun_clr;
    logic [CH-1:0] x_in;
    logic [OW-1:0] y_data;
    logic [0:0]    y_chan;
    logic x2_valid, y2_valid, y2_ready, ovr2, ovr2_clr;
    logic [0:0] x2_in, y2_chan;
    logic [1:0] y2_data;

    always #5 clk = ~clk;

    cic_decim_mc #(.N(N), .R(R), .M(M), .CH(CH), .OW(OW)) dut (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_in(x_in),
        .y_data(y_data), .y_chan(y_chan), .y_valid(y_valid), .y_ready(y_ready),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    cic_decim_mc #(.N(1), .R(4), .M(1), .CH(1), .OW(2)) dut2 (
        .clk(clk), .rst(rst), .x_valid(x2_valid), .x_in(x2_in),
        .y_data(y2_data), .y_chan(y2_chan), .y_valid(y2_valid), .y_ready(y2_ready),
        .overrun(ovr2), .overrun_clr(ovr2_clr)
    );

    typedef struct {
        logic [15:0] d;
        logic [0:0]  c;
        int          f;
    } exp_t;

    int checks = 0, errors = 0;
    longint integ [CH][N];
    longint snaps [CH][$];
    exp_t   exp_q[$];
    int     pcnt, tick_no = 0, evt_tick = -1, hs_cnt;
    bit     steady_on, lat_on, recording;
    logic signed [15:0] steady [CH];
    logic [15:0] rec[$], ref_seq[$];

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint binom(input int n, input int k);
        longint r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // Output of N cascaded (1 - z^-M) combs on the snapshot history, zero before frame 0.
    function automatic longint comb_out(input int ch);
        longint acc = 0;
        int f = snaps[ch].size() - 1;
        for (int j = 0; j <= N; j++)
            if (f - j * M >= 0)
                acc += ((j % 2) ? -1 : 1) * binom(N, j) * snaps[ch][f - j * M];
        return acc & MASK;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            snaps[c].delete();
            for (int k = 0; k < N; k++) integ[c][k] = 0;
        end
        exp_q.delete();
        pcnt = 0;
        evt_tick = -1;
    endtask

    task automatic model_step(input logic [CH-1:0] x);
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < N; k++)
                integ[c][k] = (integ[c][k] + ((k == 0) ? (x[c] ? 64'sd1 : -64'sd1) : integ[c][k-1])) & MASK;
        pcnt++;
        if (pcnt == R) begin
            pcnt = 0;
            evt_tick = tick_no;
            for (int c = 0; c < CH; c++) begin
                snaps[c].push_back(integ[c][N-1]);
                exp_q.push_back('{d: 16'(comb_out(c) >> (B - OW)), c: 1'(c), f: snaps[c].size() - 1});
            end
        end
    endtask

    task automatic tick(input logic v, input logic [CH-1:0] x, input logic rdy, input logic clr);
        exp_t e;
        x_valid = v;
        x_in = x;
        y_ready = rdy;
        overrun_clr = clr;
        #1;
        if (lat_on && evt_tick >= 0) begin
            if (tick_no == evt_tick + N + 1)     chk("lat_ch0_low", y_valid, 0);
            if (tick_no == evt_tick + N + 2)     chk("lat_ch0_high", y_valid, 1);
            if (tick_no == evt_tick + 2 * N + 2) chk("lat_ch1_low", y_valid, 0);
            if (tick_no == evt_tick + 2 * N + 3) chk("lat_ch1_high", y_valid, 1);
        end
        if (y_valid && y_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) chk("spurious_valid", y_valid, 0);
            else begin
                e = exp_q.pop_front();
                chk("y_data", $signed(y_data), $signed(e.d));
                chk("y_chan", y_chan, e.c);
                if (steady_on && e.f >= N) chk("steady", $signed(y_data), steady[e.c]);
                if (recording) rec.push_back(y_data);
            end
        end
        if (v) model_step(x);
        tick_no++;
        @(negedge clk);
    endtask

    task automatic run_const(input int n, input logic [CH-1:0] x, input bit alt);
        for (int i = 0; i < n; i++) tick(1'b1, (alt && i % 2) ? ~x : x, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        x_valid = 1'b0; x_in = '0; y_ready = 1'b0; overrun_clr = 1'b0;
        x2_valid = 1'b0; x2_in = '0; y2_ready = 1'b0; ovr2_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        hs_cnt = 0;
    endtask

    initial begin
        logic [15:0] d0;
        int e0, hs2, pidx;
        do_reset();
        chk("rst_y_data", y_data, 0);
        chk("rst_y_chan", y_chan, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_dut2_valid", y2_valid, 0);

        // all ones, also recorded for the restart comparison
        steady = '{16384, 16384}; steady_on = 1; lat_on = 1; recording = 1;
        run_const(7 * R + 20, 2'b11, 0);
        chk("ones_count", hs_cnt, 14);
        chk("ones_no_overrun", overrun, 0);
        ref_seq = rec; rec.delete(); recording = 0;

        do_reset();
        steady = '{-16384, -16384};
        run_const(7 * R + 20, 2'b00, 0);
        chk("zeros_count", hs_cnt, 14);

        do_reset();
        steady = '{0, 0};
        run_const(7 * R + 20, 2'b11, 1);
        chk("alt_count", hs_cnt, 14);

        do_reset();
        steady = '{16384, -16384};
        run_const(7 * R + 20, 2'b01, 0);
        chk("split_count", hs_cnt, 14);

        // random bits, strobe and backpressure
        do_reset();
        steady_on = 0; lat_on = 0;
        for (int i = 0; i < 600; i++)
            tick($urandom_range(0, 9) < 7, 2'($urandom), $urandom_range(0, 4) != 0, 1'b0);
        for (int i = 0; i < 40; i++) tick(1'b0, 2'b00, 1'b1, 1'b0);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_no_overrun", overrun, 0);

        // stall past a full decimation period
        do_reset();
        run_const(2 * R + 20, 2'b11, 0);
        for (int i = 0; i < 100 && !y_valid; i++) tick(1'b1, 2'b11, 1'b0, 1'b0);
        chk("stall_valid", y_valid, 1);
        d0 = y_data;
        if (exp_q.size() > 0) chk("stall_head", $signed(y_data), $signed(exp_q[0].d));
        repeat (2 * R) tick(1'b1, 2'b11, 1'b0, 1'b0);
        chk("stall_overrun", overrun, 1);
        chk("stall_hold", y_data, d0);
        chk("stall_still_valid", y_valid, 1);
        e0 = evt_tick;
        for (int i = 0; i < R + 8; i++) begin
            tick(1'b1, 2'b11, 1'b0, 1'b1);
            if (evt_tick != e0 && tick_no == evt_tick + 2) chk("ovr_set_wins", overrun, 1);
            if (evt_tick != e0 && tick_no == evt_tick + 3) chk("ovr_cleared", overrun, 0);
        end
        chk("stall_hold_end", y_data, d0);

        // asynchronous reset while the comb engine is busy
        do_reset();
        run_const(6 * R, 2'b11, 0);
        for (int i = 0; i < 8 && tick_no != evt_tick + 3; i++) tick(1'b1, 2'b11, 1'b1, 1'b0);
        chk("mid_comb_valid", y_valid, 0);
        chk("mid_pre_y", $signed(y_data), 16384);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_y_data", y_data, 0);
        chk("mid_rst_valid", y_valid, 0);
        chk("mid_rst_chan", y_chan, 0);
        @(negedge clk);
        x_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        hs_cnt = 0;
        steady = '{16384, 16384}; steady_on = 1; recording = 1;
        run_const(7 * R + 20, 2'b11, 0);
        chk("restart_len", rec.size(), ref_seq.size());
        for (int i = 0; i < ref_seq.size() && i < rec.size(); i++) chk("restart_seq", rec[i], ref_seq[i]);
        recording = 0; steady_on = 0;

        // small instance: window 1,1,1,0 sums to +2
        do_reset();
        hs2 = 0; pidx = 0;
        for (int i = 0; i < 170; i++) begin
            x2_valid = (i % 2 == 0) && (i < 160);
            x2_in = 1'(pidx % 4 != 3);
            if (x2_valid) pidx++;
            y2_ready = 1'b1;
            #1;
            if (y2_valid) begin
                hs2++;
                chk("small_y", $signed(y2_data), RND_EXP);
                chk("small_chan", y2_chan, 0);
            end
            @(negedge clk);
        end
        chk("small_count", hs2, 20);
        chk("small_overrun", ovr2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
